// File: rtl/ghost_position_tracker.sv
// Tile-position register for one ghost: timed tile steps with wall checks, respawn to home.
// Optional side-tunnel wrap on row TUNNEL_Y is compiled in with GHOST_TUNNEL_WRAP_EN.
module ghost_position_tracker #(
    parameter int unsigned GRID_W     = 28,
    parameter int unsigned GRID_H     = 31,
    parameter int unsigned START_X    = 13,
    parameter int unsigned START_Y    = 11,
    parameter int unsigned STEP_TICKS = 8,
    parameter int unsigned TUNNEL_Y   = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      enable,
    input  logic                      respawn,
    input  logic [1:0]                dirToMove,
    input  logic                      canMoveU,
    input  logic                      canMoveR,
    input  logic                      canMoveD,
    input  logic                      canMoveL,
    output logic [$clog2(GRID_W)-1:0] ghostPosX,
    output logic [$clog2(GRID_H)-1:0] ghostPosY,
    output logic [1:0]                ghostDir,
    output logic                      moved
);

    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);
    localparam int unsigned CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

`ifdef GHOST_TUNNEL_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] DIR_U = 2'b00;
    localparam logic [1:0] DIR_R = 2'b01;
    localparam logic [1:0] DIR_D = 2'b10;
    localparam logic [1:0] DIR_L = 2'b11;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        COUNT = 2'b01,
        STEP  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic [1:0]      dir_d;
    logic            moved_d;
    logic [3:0]      flags;
    logic            req_ok, alt_ok;
    logic [XW-1:0]   req_x, alt_x;
    logic [YW-1:0]   req_y, alt_y;

    assign flags = {canMoveU, canMoveR, canMoveD, canMoveL};

    // Legality and destination of a one-tile move in direction d; flags ordered {U,R,D,L}.
    function automatic logic [XW+YW:0] try_dir(input logic [1:0] d, input logic [3:0] f,
                                               input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic          ok;
        logic [XW-1:0] nx;
        logic [YW-1:0] ny;
        logic          wrap_row;
        ok       = 1'b0;
        nx       = x;
        ny       = y;
        wrap_row = WRAP_EN && (y == YW'(TUNNEL_Y));
        case (d)
            DIR_U: begin
                ok = f[3] && (y != '0);
                ny = y - YW'(1);
            end
            DIR_R: begin
                if (x != XW'(GRID_W - 1)) begin
                    ok = f[2];
                    nx = x + XW'(1);
                end else if (wrap_row) begin
                    ok = f[2];
                    nx = '0;
                end
            end
            DIR_D: begin
                ok = f[1] && (y != YW'(GRID_H - 1));
                ny = y + YW'(1);
            end
            default: begin
                if (x != '0) begin
                    ok = f[0];
                    nx = x - XW'(1);
                end else if (wrap_row) begin
                    ok = f[0];
                    nx = XW'(GRID_W - 1);
                end
            end
        endcase
        return {ok, nx, ny};
    endfunction

    // Next-state, tick counter and step resolution.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = ghostPosX;
        y_d     = ghostPosY;
        dir_d   = ghostDir;
        moved_d = 1'b0;
        {req_ok, req_x, req_y} = try_dir(dirToMove, flags, ghostPosX, ghostPosY);
        {alt_ok, alt_x, alt_y} = try_dir(ghostDir, flags, ghostPosX, ghostPosY);

        if (respawn) begin
            state_d = enable ? COUNT : HOLD;
            cnt_d   = '0;
            x_d     = XW'(START_X);
            y_d     = YW'(START_Y);
            dir_d   = DIR_L;
        end else begin
            case (state_q)
                HOLD: begin
                    if (enable) state_d = COUNT;
                end
                COUNT: begin
                    if (!enable) begin
                        state_d = HOLD;
                    end else if (tick) begin
                        if (cnt_q == CW'(STEP_TICKS - 1)) begin
                            cnt_d   = '0;
                            state_d = STEP;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                STEP: begin
                    state_d = enable ? COUNT : HOLD;
                    if (req_ok) begin
                        x_d     = req_x;
                        y_d     = req_y;
                        dir_d   = dirToMove;
                        moved_d = 1'b1;
                    end else if (alt_ok) begin
                        x_d     = alt_x;
                        y_d     = alt_y;
                        moved_d = 1'b1;
                    end
                end
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            ghostPosX <= XW'(START_X);
            ghostPosY <= YW'(START_Y);
            ghostDir  <= DIR_L;
            moved     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ghostPosX <= x_d;
            ghostPosY <= y_d;
            ghostDir  <= dir_d;
            moved     <= moved_d;
        end
    end

endmodule

// File: tb/tb_ghost_position_tracker.sv
// Directed bench for ghost_position_tracker: expected step outcomes queued at stimulus time,
// popped and compared when the step result is due.
module tb_ghost_position_tracker;

    logic       clk = 1'b0;
    logic       reset, tick, enable, respawn;
    logic [1:0] dirToMove;
    logic       canMoveU, canMoveR, canMoveD, canMoveL;
    logic [4:0] ghostPosX, ghostPosY;
    logic [1:0] ghostDir;
    logic       moved;

    typedef struct {
        bit         mv;
        int         x;
        int         y;
        logic [1:0] d;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cur_x    = 13;
    int         cur_y    = 11;
    logic [1:0] cur_d    = 2'b11;

    ghost_position_tracker #(
        .GRID_W(28), .GRID_H(31), .START_X(13), .START_Y(11), .STEP_TICKS(8), .TUNNEL_Y(14)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .respawn(respawn),
        .dirToMove(dirToMove),
        .canMoveU(canMoveU), .canMoveR(canMoveR), .canMoveD(canMoveD), .canMoveL(canMoveL),
        .ghostPosX(ghostPosX), .ghostPosY(ghostPosY), .ghostDir(ghostDir), .moved(moved)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        {canMoveU, canMoveR, canMoveD, canMoveL} = f;
    endtask

    // Hold tick high for n rising edges; returns at a falling edge with tick low.
    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic settle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input bit mv, input int x, input int y, input logic [1:0] d);
        exp_t e;
        e.mv = mv;
        e.x  = mv ? x : cur_x;
        e.y  = mv ? y : cur_y;
        e.d  = mv ? d : cur_d;
        sb.push_back(e);
        cur_x = e.x;
        cur_y = e.y;
        cur_d = e.d;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "/moved"}, 32'(moved), 32'(e.mv));
        chk({tag, "/x"}, 32'(ghostPosX), 32'(e.x));
        chk({tag, "/y"}, 32'(ghostPosY), 32'(e.y));
        chk({tag, "/dir"}, 32'(ghostDir), 32'(e.d));
        if (e.mv) begin
            settle;
            chk({tag, "/pulse_end"}, 32'(moved), 32'd0);
        end
    endtask

    // One full 8-tick period; result expected two edges after the last tick.
    task automatic step_to(input logic [1:0] d, input logic [3:0] f, input bit mv,
                           input int ex, input int ey, input logic [1:0] ed, input string tag);
        dirToMove = d;
        set_flags(f);
        push(mv, ex, ey, ed);
        ticks(8);
        chk({tag, "/early"}, 32'(moved), 32'd0);
        settle;
        check_out(tag);
    endtask

    task automatic chk_home(input string tag);
        chk({tag, "/x"}, 32'(ghostPosX), 32'd13);
        chk({tag, "/y"}, 32'(ghostPosY), 32'd11);
        chk({tag, "/dir"}, 32'(ghostDir), 32'd3);
        chk({tag, "/moved"}, 32'(moved), 32'd0);
        cur_x = 13;
        cur_y = 11;
        cur_d = 2'b11;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; enable = 1'b0; respawn = 1'b0; dirToMove = 2'b00;
        set_flags(4'b0000);
        @(negedge clk);
        @(negedge clk);
        chk_home("reset");

        reset  = 1'b1;
        enable = 1'b1;
        settle;
        step_to(2'b01, 4'b0100, 1'b1, 14, 11, 2'b01, "first_step");
        step_to(2'b00, 4'b0100, 1'b1, 15, 11, 2'b01, "fallback");
        step_to(2'b00, 4'b0000, 1'b0, 15, 11, 2'b01, "blocked");

        for (int i = 0; i < 3; i++) step_to(2'b10, 4'b1111, 1'b1, cur_x, cur_y + 1, 2'b10, "walk_d");
        for (int i = 0; i < 15; i++) step_to(2'b11, 4'b1111, 1'b1, cur_x - 1, cur_y, 2'b11, "walk_l");
`ifdef GHOST_TUNNEL_WRAP_EN
        step_to(2'b11, 4'b0001, 1'b1, 27, 14, 2'b11, "tunnel");
`else
        step_to(2'b11, 4'b0001, 1'b0, 0, 14, 2'b11, "tunnel");
`endif

        respawn = 1'b1;
        settle;
        respawn = 1'b0;
        chk_home("respawn");

        for (int i = 0; i < 7; i++) step_to(2'b01, 4'b1111, 1'b1, cur_x + 1, cur_y, 2'b01, "walk_r");
        for (int i = 0; i < 6; i++) step_to(2'b00, 4'b1111, 1'b1, cur_x, cur_y - 1, 2'b00, "walk_u");
        chk("at_20_5/x", 32'(ghostPosX), 32'd20);
        chk("at_20_5/y", 32'(ghostPosY), 32'd5);

        // Respawn lands in the STEP cycle: home wins, no step, counter cleared.
        dirToMove = 2'b00;
        set_flags(4'b1111);
        ticks(8);
        respawn = 1'b1;
        settle;
        respawn = 1'b0;
        chk_home("respawn_step");
        dirToMove = 2'b01;
        set_flags(4'b0100);
        ticks(7);
        settle;
        chk("respawn_cnt/moved", 32'(moved), 32'd0);
        chk("respawn_cnt/x", 32'(ghostPosX), 32'd13);
        push(1'b1, 14, 11, 2'b01);
        ticks(1);
        settle;
        check_out("respawn_cnt");

        // Enable drop keeps the count: 5 + 3 ticks give a step.
        ticks(5);
        enable = 1'b0;
        ticks(10);
        chk("frozen/moved", 32'(moved), 32'd0);
        chk("frozen/x", 32'(ghostPosX), 32'd14);
        enable = 1'b1;
        settle;
        ticks(2);
        settle;
        chk("resume_early/moved", 32'(moved), 32'd0);
        chk("resume_early/x", 32'(ghostPosX), 32'd14);
        push(1'b1, 15, 11, 2'b01);
        ticks(1);
        settle;
        check_out("resume");

        // A tick in the STEP cycle is dropped.
        push(1'b1, 16, 11, 2'b01);
        ticks(9);
        check_out("step_tick");
        ticks(7);
        settle;
        chk("dropped_tick/moved", 32'(moved), 32'd0);
        chk("dropped_tick/x", 32'(ghostPosX), 32'd16);
        push(1'b1, 17, 11, 2'b01);
        ticks(1);
        settle;
        check_out("after_drop");

        // Asynchronous reset mid-count, off the clock edge.
        ticks(3);
        #3 reset = 1'b0;
        #1 chk_home("async_reset");
        @(negedge clk);
        reset = 1'b1;
        ticks(8);
        settle;
        chk("hold_resume/moved", 32'(moved), 32'd0);
        chk("hold_resume/x", 32'(ghostPosX), 32'd13);
        push(1'b1, 14, 11, 2'b01);
        ticks(1);
        settle;
        check_out("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
